// File: rtl/fir_poly_bank_mc.sv
// ---------------------------------------------------------------------------
// fir_poly_bank_mc
//
// Multi-channel polyphase FIR sub-filter bank. Each accepted input beat
// carries one signed sample per channel. The samples are shifted into
// per-channel delay lines of BANK_LEN taps. A single multiply-accumulate
// unit is then shared across the channels, one tap per cycle. One dot product
// per channel leaves over a valid/ready output, either sign-extended or
// saturated to OUTPUT_WIDTH.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous reset, active-high
//   coef_wr_en    coefficient write strobe (honoured only while idle)
//   coef_wr_addr  coefficient index k (dropped when k >= BANK_LEN)
//   coef_wr_data  signed coefficient value
//   din           N_CHAN packed samples, channel c at [c*INPUT_WIDTH +: INPUT_WIDTH]
//   din_valid     input beat valid
//   din_ready     high only while idle and out of reset
//   dout          signed filter result for channel dout_chan
//   dout_chan     channel index of dout
//   dout_valid    result valid, held until accepted
//   dout_ready    downstream accepts result
// ---------------------------------------------------------------------------
module fir_poly_bank_mc #(
  parameter int BANK_LEN     = 6,
  parameter int N_CHAN       = 2,
  parameter int INPUT_WIDTH  = 12,
  parameter int TAP_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 35,
  localparam int ACC_W = INPUT_WIDTH + TAP_WIDTH + $clog2(BANK_LEN),
  localparam int AW    = (BANK_LEN > 1) ? $clog2(BANK_LEN) : 1,
  localparam int CW    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             coef_wr_en,
  input  logic [AW-1:0]                    coef_wr_addr,
  input  logic signed [TAP_WIDTH-1:0]      coef_wr_data,
  input  logic [N_CHAN*INPUT_WIDTH-1:0]    din,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic [OUTPUT_WIDTH-1:0]          dout,
  output logic [CW-1:0]                    dout_chan,
  output logic                             dout_valid,
  input  logic                             dout_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int PROD_W = INPUT_WIDTH + TAP_WIDTH;

  // One extra bit so BANK_LEN itself is representable even when it is a power of two.
  localparam logic [AW:0]   BANK_LEN_X = (AW+1)'(BANK_LEN);
  localparam logic [AW-1:0] K_LAST     = AW'(BANK_LEN - 1);
  localparam logic [CW-1:0] CHAN_LAST  = CW'(N_CHAN - 1);

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 chan_q, chan_d;
  logic [AW-1:0]                 k_q, k_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [TAP_WIDTH-1:0]   coef_q [BANK_LEN];
  logic signed [TAP_WIDTH-1:0]   coef_d [BANK_LEN];
  logic signed [INPUT_WIDTH-1:0] hist_q [N_CHAN][BANK_LEN];
  logic signed [INPUT_WIDTH-1:0] hist_d [N_CHAN][BANK_LEN];

  logic                          din_accept;
  logic                          coef_wr_ok;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       term;

  // Input is only taken while idle. Reset also masks ready, so a beat offered
  // in a reset cycle is never treated as accepted.
  assign din_ready  = (state_q == ST_IDLE) && !rst;
  assign din_accept = din_valid && din_ready;
  assign coef_wr_ok = coef_wr_en && (state_q == ST_IDLE) &&
                      ({1'b0, coef_wr_addr} < BANK_LEN_X);

  assign dout_valid = (state_q == ST_OUT);
  assign dout_chan  = chan_q;

  // The single shared multiplier. It forms the product of the current tap and
  // the channel sample, then sign-extends it into the accumulator width.
  always_comb begin
    prod = PROD_W'(coef_q[k_q]) * PROD_W'(hist_q[chan_q][k_q]);
    term = ACC_W'(prod);
  end

  // Next-state logic for the controller, the delay lines, the coefficient
  // store and the accumulator. The coefficient write is applied here together
  // with a coincident input beat. MAC reads the registered copy from the
  // following cycle, so that beat already sees the new value.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    k_d     = k_q;
    acc_d   = acc_q;
    coef_d  = coef_q;
    hist_d  = hist_q;

    if (coef_wr_ok) begin
      coef_d[coef_wr_addr] = coef_wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (din_accept) begin
          for (int c = 0; c < N_CHAN; c++) begin
            for (int k = 1; k < BANK_LEN; k++) begin
              hist_d[c][k] = hist_q[c][k-1];
            end
            hist_d[c][0] = din[c*INPUT_WIDTH +: INPUT_WIDTH];
          end
          chan_d  = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end

      ST_MAC: begin
        acc_d = ((k_q == '0) ? '0 : acc_q) + term;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (dout_ready) begin
          if (chan_q != CHAN_LAST) begin
            chan_d  = chan_q + 1'b1;
            k_d     = '0;
            state_d = ST_MAC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset. Reset clears everything, including
  // the coefficients and delay lines, so a partial result in flight is simply lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < BANK_LEN; k++) begin
        coef_q[k] <= '0;
      end
      for (int c = 0; c < N_CHAN; c++) begin
        for (int k = 0; k < BANK_LEN; k++) begin
          hist_q[c][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      coef_q  <= coef_d;
      hist_q  <= hist_d;
    end
  end

  // Output conversion. The accumulator is stable for the whole OUT state, so
  // dout holds steady under backpressure without an extra register.
  generate
    if (OUTPUT_WIDTH >= ACC_W) begin : g_ext
      assign dout = OUTPUT_WIDTH'(acc_q);
    end else begin : g_sat
      localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

      // Clamp to the signed range of OUTPUT_WIDTH.
      always_comb begin
        if (acc_q > MAX_V) begin
          dout = MAX_V[OUTPUT_WIDTH-1:0];
        end else if (acc_q < MIN_V) begin
          dout = MIN_V[OUTPUT_WIDTH-1:0];
        end else begin
          dout = acc_q[OUTPUT_WIDTH-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fir_poly_bank_mc.sv
// ---------------------------------------------------------------------------
// tb_fir_poly_bank_mc
//
// Self-checking bench for fir_poly_bank_mc. It drives two instances in
// lockstep: one at the default output width and one at OUTPUT_WIDTH=20. The
// narrow instance exercises saturation. A behavioural model of the
// coefficients and delay lines pushes the expected per-channel results when a
// beat is accepted. A monitor pops and compares them on each output handshake.
// ---------------------------------------------------------------------------
module tb_fir_poly_bank_mc;

   localparam int BL  = 6;
   localparam int NC  = 2;
   localparam int IW  = 12;
   localparam int TW  = 16;
   localparam int OW  = 35;
   localparam int OWS = 20;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 coef_wr_en;
   logic [2:0]           coef_wr_addr;
   logic signed [TW-1:0] coef_wr_data;
   logic [NC*IW-1:0]     din;
   logic                 din_valid;
   logic                 din_ready;
   logic                 sat_din_ready;
   logic signed [OW-1:0] dout;
   logic signed [OWS-1:0] sat_dout;
   logic [0:0]           dout_chan;
   logic [0:0]           sat_chan;
   logic                 dout_valid;
   logic                 sat_valid;
   logic                 dout_ready;

   typedef struct {
      int     chan;
      longint wide;
      longint narrow;
   } exp_t;

   exp_t   sb [$];
   longint coef_m [BL];
   longint hist_m [NC][BL];
   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   int     hs_cyc = 0;

   // Free-running clock and cycle counter used for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   fir_poly_bank_mc #(
      .BANK_LEN(BL), .N_CHAN(NC), .INPUT_WIDTH(IW), .TAP_WIDTH(TW), .OUTPUT_WIDTH(OW)
   ) u_dut (
      .clk(clk), .rst(rst),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_chan(dout_chan), .dout_valid(dout_valid), .dout_ready(dout_ready)
   );

   fir_poly_bank_mc #(
      .BANK_LEN(BL), .N_CHAN(NC), .INPUT_WIDTH(IW), .TAP_WIDTH(TW), .OUTPUT_WIDTH(OWS)
   ) u_sat (
      .clk(clk), .rst(rst),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .din(din), .din_valid(din_valid), .din_ready(sat_din_ready),
      .dout(sat_dout), .dout_chan(sat_chan), .dout_valid(sat_valid), .dout_ready(dout_ready)
   );

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input longint obs, input longint exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic longint sat20(input longint v);
      if (v > 524287)  return 524287;
      if (v < -524288) return -524288;
      return v;
   endfunction

   // Model of one accepted beat: shift every delay line, then queue each channel's dot product.
   task automatic modelBeat(input longint s0, input longint s1);
      exp_t e;
      longint sum;
      for (int c = 0; c < NC; c++) begin
         for (int k = BL-1; k >= 1; k--) hist_m[c][k] = hist_m[c][k-1];
         hist_m[c][0] = (c == 0) ? s0 : s1;
      end
      for (int c = 0; c < NC; c++) begin
         sum = 0;
         for (int k = 0; k < BL; k++) sum += coef_m[k] * hist_m[c][k];
         e.chan   = c;
         e.wide   = sum;
         e.narrow = sat20(sum);
         sb.push_back(e);
      end
   endtask

   // Offer one beat, optionally with a coincident coefficient write, and wait (bounded) for acceptance.
   task automatic applyStimulus(input int s0, input int s1, input logic we,
                                input logic [2:0] wa, input int wd);
      int n;
      din          = {IW'(s1), IW'(s0)};
      din_valid    = 1'b1;
      coef_wr_en   = we;
      coef_wr_addr = wa;
      coef_wr_data = TW'(wd);
      n = 0;
      while (!din_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!din_ready) begin
         checkOutput("din_accept_timeout", 0, 1);
      end else begin
         @(posedge clk);
         if (we && wa < BL) coef_m[wa] = wd;
         modelBeat(s0, s1);
         hs_cyc = cyc;
         #1;
      end
      din_valid  = 1'b0;
      coef_wr_en = 1'b0;
   endtask

   task automatic writeCoef(input logic [2:0] addr, input int data, input bit model_applies);
      coef_wr_en   = 1'b1;
      coef_wr_addr = addr;
      coef_wr_data = TW'(data);
      @(posedge clk);
      if (model_applies && addr < BL) coef_m[addr] = data;
      #1;
      coef_wr_en = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         checkOutput("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic waitCh0();
      int n;
      n = 0;
      while (!(dout_valid === 1'b1 && dout_chan === 1'b0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) checkOutput("wait_ch0_timeout", 0, 1);
   endtask

   // Scoreboard monitor: sample mid-cycle. A valid with ready means the next edge
   // completes the transfer, so pop and compare then.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_output", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("dout_chan", dout_chan, e.chan);
            checkOutput("dout", dout, e.wide);
            checkOutput("sat_dout", sat_dout, e.narrow);
            checkOutput("sat_valid", sat_valid, 1);
            checkOutput("sat_chan", sat_chan, e.chan);
         end
      end
   end

   // Directed sequence.
   initial begin
      int t0, t1, tr, n;
      int imp_seq [7];
      longint hold_exp;
      imp_seq = '{1, 2, 3, 4, 5, 6, 0};

      rst          = 1'b1;
      coef_wr_en   = 1'b0;
      coef_wr_addr = '0;
      coef_wr_data = '0;
      din          = '0;
      din_valid    = 1'b0;
      dout_ready   = 1'b1;
      for (int k = 0; k < BL; k++) coef_m[k] = 0;
      for (int c = 0; c < NC; c++) for (int k = 0; k < BL; k++) hist_m[c][k] = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_din_ready", din_ready, 0);
      checkOutput("rst_dout_valid", dout_valid, 0);
      checkOutput("rst_dout", dout, 0);
      checkOutput("rst_dout_chan", dout_chan, 0);
      rst = 1'b0;
      #1;
      checkOutput("idle_din_ready", din_ready, 1);

      // Impulse response: coef[k]=k+1
      $display("[TB] impulse");
      for (int k = 0; k < BL; k++) writeCoef(3'(k), k + 1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus((i == 0) ? 1 : 0, 0, 1'b0, 3'd0, 0);
         waitCh0();
         checkOutput("impulse_ch0", dout, imp_seq[i]);
         drain();
      end

      // Latency with dout_ready held high
      $display("[TB] latency");
      applyStimulus(3, 4, 1'b0, 3'd0, 0);
      t0 = -1; t1 = -1; tr = -1;
      for (int i = 0; i < 40; i++) begin
         if (dout_valid && dout_chan == 1'b0 && t0 < 0) t0 = cyc - hs_cyc;
         if (dout_valid && dout_chan == 1'b1 && t1 < 0) t1 = cyc - hs_cyc;
         if (din_ready && tr < 0) tr = cyc - hs_cyc;
         @(posedge clk); #1;
      end
      checkOutput("lat_ch0", t0, 7);
      checkOutput("lat_ch1", t1, 14);
      checkOutput("lat_din_ready", tr, 15);
      drain();

      // Backpressure: stall five cycles in channel 0 OUT
      $display("[TB] backpressure");
      applyStimulus(-100, 50, 1'b0, 3'd0, 0);
      waitCh0();
      checkOutput("bp_ch0_lat", cyc - hs_cyc, 7);
      dout_ready = 1'b0;
      hold_exp = (sb.size() != 0) ? sb[0].wide : 0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", dout_valid, 1);
         checkOutput("bp_chan", dout_chan, 0);
         checkOutput("bp_dout", dout, hold_exp);
         @(posedge clk); #1;
      end
      dout_ready = 1'b1;
      n = 0;
      while (!(dout_valid === 1'b1 && dout_chan === 1'b1) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("bp_ch1_lat", cyc - hs_cyc, 19);
      drain();

      // Coincident coefficient write applies to that same beat
      $display("[TB] coincident write");
      applyStimulus(9, -9, 1'b1, 3'd3, -1234);
      drain();

      // Saturation: all coefficients at 32767, delay lines full of extremes
      $display("[TB] saturation");
      for (int k = 0; k < BL; k++) writeCoef(3'(k), 32767, 1'b1);
      for (int i = 0; i < BL - 1; i++) begin
         applyStimulus(2047, 2047, 1'b0, 3'd0, 0);
         drain();
      end
      applyStimulus(2047, 2047, 1'b0, 3'd0, 0);
      waitCh0();
      checkOutput("sat_pos_narrow", sat_dout, 524287);
      checkOutput("sat_pos_wide", dout, 402444294);
      drain();
      for (int i = 0; i < BL - 1; i++) begin
         applyStimulus(-2048, -2048, 1'b0, 3'd0, 0);
         drain();
      end
      applyStimulus(-2048, -2048, 1'b0, 3'd0, 0);
      waitCh0();
      checkOutput("sat_neg_narrow", sat_dout, -524288);
      checkOutput("sat_neg_wide", dout, -402640896);
      drain();

      // Coefficient gating: write during MAC and out-of-range address are dropped;
      // din_valid during MAC is ignored
      $display("[TB] coefficient gating");
      applyStimulus(5, 3, 1'b0, 3'd0, 0);
      @(posedge clk); #1;
      writeCoef(3'd0, 100, 1'b0);
      din       = {IW'(77), IW'(-77)};
      din_valid = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      din_valid = 1'b0;
      drain();
      applyStimulus(1, 0, 1'b0, 3'd0, 0);
      drain();
      writeCoef(3'd7, 555, 1'b1);
      applyStimulus(0, 1, 1'b0, 3'd0, 0);
      drain();

      // Reset mid-MAC; a beat offered during reset is discarded
      $display("[TB] reset mid-MAC");
      applyStimulus(7, 7, 1'b0, 3'd0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_mac_valid", dout_valid, 0);
      checkOutput("rst_mac_din_ready", din_ready, 0);
      din       = {IW'(2047), IW'(2047)};
      din_valid = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      din_valid = 1'b0;
      sb.delete();
      for (int k = 0; k < BL; k++) coef_m[k] = 0;
      for (int c = 0; c < NC; c++) for (int k = 0; k < BL; k++) hist_m[c][k] = 0;
      #1;
      checkOutput("post_rst_din_ready", din_ready, 1);
      checkOutput("post_rst_dout_valid", dout_valid, 0);
      applyStimulus(1, 0, 1'b0, 3'd0, 0);
      waitCh0();
      checkOutput("post_rst_impulse", dout, 0);
      drain();
      writeCoef(3'd1, 1, 1'b1);
      writeCoef(3'd2, 1, 1'b1);
      applyStimulus(0, 0, 1'b0, 3'd0, 0);
      drain();

      checkOutput("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fir_poly_bank_mc.md
# fir_poly_bank_mc

Parametrised multi-channel polyphase FIR sub-filter bank. Each accepted input beat carries one sample per channel. The block shifts those samples into per-channel delay lines of depth BANK_LEN. It then time-multiplexes a single multiply-accumulate unit across all channels and emits one full-precision (or saturated) dot product per channel over a valid/ready output. It is the per-phase building block of the generalised polyphase decimator, replacing the fixed-length, single-channel, tap-address-driven bank.

## Interface
- BANK_LEN, 6, taps per bank (≥2)
- N_CHAN, 2, channels per input beat (≥1)
- INPUT_WIDTH, 12, signed sample width
- TAP_WIDTH, 16, signed coefficient width
- OUTPUT_WIDTH, 35, signed output width
- Derived: ACC_W = INPUT_WIDTH+TAP_WIDTH+clog2(BANK_LEN); AW = max(1,clog2(BANK_LEN)); CW = max(1,clog2(N_CHAN))

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  AW  coefficient index k
- coef_wr_data  in  TAP_WIDTH  signed coefficient value
- din  in  N_CHAN*INPUT_WIDTH  channel c occupies bits [c*INPUT_WIDTH +: INPUT_WIDTH]
- din_valid  in  1  input beat valid
- din_ready  out  1  block can accept a beat
- dout  out  OUTPUT_WIDTH  signed filter result
- dout_chan  out  CW  channel index of dout
- dout_valid  out  1  result valid
- dout_ready  in  1  downstream accepts result

## Operation
- Storage: coef[0..BANK_LEN-1]; hist[c][0..BANK_LEN-1], where index 0 is the newest sample.
- Reset clears coef, hist, acc, chan and k to 0, and sets state to IDLE. Output reset values: din_ready=0 during rst, dout=0, dout_chan=0, dout_valid=0.
- FSM states: IDLE, MAC, OUT.
  - IDLE: din_ready=1. On din_valid, every hist[c] shifts (hist[c][k] <= hist[c][k-1]; hist[c][0] <= din lane c). Then chan=0, k=0, next state MAC.
  - MAC: one term per cycle. acc <= (k==0 ? 0 : acc) + coef[k]*hist[chan][k], full precision in ACC_W bits. k increments; after k==BANK_LEN-1 the next state is OUT.
  - OUT: dout_valid=1, dout=conv(acc), dout_chan=chan.
    - On dout_ready with chan<N_CHAN-1: chan++, k=0, next state MAC.
    - On dout_ready with chan==N_CHAN-1: next state IDLE.
    - Without dout_ready: hold state; dout and dout_chan stay stable.
- conv(): if OUTPUT_WIDTH ≥ ACC_W, sign-extend. Otherwise saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
- Coefficient writes:
  - Take effect only in IDLE and with coef_wr_addr < BANK_LEN; all other writes are dropped.
  - A write coincident with a din handshake in IDLE is applied, and the value is used by that beat's computation.
- din_ready=0 outside IDLE; din_valid there is ignored and no shift occurs.
- A din handshake and rst in the same cycle: rst wins, and the beat is discarded.
- rst mid-MAC or mid-OUT: next cycle is IDLE with dout_valid=0; the partial result is lost.

## Timing
- Handshake on din at cycle t puts the block in MAC for cycles t+1..t+BANK_LEN. Channel 0's dout_valid rises at t+BANK_LEN+1.
- With dout_ready held high:
  - Channel c is valid at t+(c+1)(BANK_LEN+1).
  - The block returns to IDLE at t+N_CHAN(BANK_LEN+1)+1.
  - Input throughput is one beat per N_CHAN(BANK_LEN+1)+1 cycles.
- Each cycle of dout_ready stall adds exactly one cycle to every later event of that beat.
- dout_valid never drops without a completed handshake (except on rst).
- Coefficient write latency: a write in cycle c is visible to MAC reads from cycle c+1.

## Test plan
- Impulse: coef[k]=k+1. Feed ch0 samples 1,0,0,0,0,0,0 with ch1=0. Ch0 dout sequence must be 1,2,3,4,5,6,0; ch1 dout must be 0 every beat.
- Latency (BANK_LEN=6, N_CHAN=2, dout_ready=1): din handshake at cycle 0 gives ch0 valid at cycle 7 and ch1 valid at cycle 14; din_ready must reassert at cycle 15.
- Backpressure: hold dout_ready=0 for 5 cycles during ch0 OUT. dout, dout_chan and dout_valid must stay stable; ch1 valid must be delayed by exactly 5 cycles.
- Saturation (OUTPUT_WIDTH=20): all coef=32767.
  - Inputs all 2047 gives 524287.
  - Inputs all -2048 gives -524288.
  - Default width, inputs all -2048, gives -402640896 exactly.
- Coefficient gating:
  - Write coef[0]=100 during MAC: the result is unchanged and a readback via impulse shows the old value.
  - Write with coef_wr_addr=7: no coefficient changes.
- Reset mid-MAC: assert rst at MAC cycle 3.
  - Next cycle: IDLE, dout_valid=0.
  - A subsequent impulse gives all-zero output (coefs cleared), with din_ready=1 after rst deasserts.
